// File: rtl/ball_game_ctrl.sv
// ----------------------------------------------------------------------------
// ball_game_ctrl
// Frame-based controller for a camera "keep the ball up" game. A ball square
// falls under gravity and bounces off the side walls. When enough camera
// pixels inside the ball square match the player marker during a frame, the
// ball is kicked upward and the score increments. The game ends when the ball
// reaches the floor.
//
// Optional feature: define BALL_SPEEDUP_EN to make the horizontal speed grow
// with the score (|vx| = 2 + score/10, capped at 5, updated on each hit).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   frame_tick   one-cycle pulse per frame (vertical blank)
//   pixel_en     current cycle carries a valid active pixel
//   is_hit_area  current pixel lies inside the ball square
//   hit_pixel    current camera pixel matches the player marker
//   btn_start    debounced start button (level)
//   ball_x/y     ball top-left position
//   score        hit count, 0..99
//   game_over    high in state OVER
//   is_idle      high in state IDLE
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ball_game_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BALL_SIZE       = 20,
  parameter int START_X         = 310,
  parameter int START_Y         = 40,
  parameter int HIT_THRESHOLD   = 40,
  parameter int JUMP_VEL        = 8,
  parameter int MAX_FALL        = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pixel_en,
  input  logic       is_hit_area,
  input  logic       hit_pixel,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic       is_idle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic signed [10:0] X_MAX     = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX     = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] JUMP      = 11'(JUMP_VEL);
  localparam logic signed [10:0] FALL_CAP  = 11'(MAX_FALL);
  localparam logic signed [10:0] VX_INIT   = 11'sd2;
  localparam logic [9:0]         X0        = 10'(START_X);
  localparam logic [9:0]         Y0        = 10'(START_Y);
  localparam logic [8:0]         HIT_THR   = 9'(HIT_THRESHOLD);
  localparam logic [8:0]         HIT_SAT   = 9'd400;
  localparam logic [7:0]         COOL_INIT = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0]         SCORE_MAX = 8'd99;

  state_t             r_state, w_state_nxt;
  logic               r_btn_d;
  logic [8:0]         r_hit_cnt, w_hit_cnt_nxt;
  logic [7:0]         r_cool, w_cool_nxt;
  logic signed [10:0] r_vx, w_vx_nxt;
  logic signed [10:0] r_vy, w_vy_nxt;
  logic [9:0]         r_x, w_x_nxt;
  logic [9:0]         r_y, w_y_nxt;
  logic [7:0]         r_score, w_score_nxt;
  logic               r_game_over, r_is_idle;

  logic               w_start, w_qual, w_hit;
  logic [7:0]         w_score_inc;
  logic signed [10:0] w_vx_base, w_vy_upd, w_new_x, w_new_y;
`ifdef BALL_SPEEDUP_EN
  logic [7:0]         w_mag;
`endif

  // Next-state, hit counter and per-frame physics
  always_comb begin
    w_state_nxt   = r_state;
    w_cool_nxt    = r_cool;
    w_vx_nxt      = r_vx;
    w_vy_nxt      = r_vy;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_score_nxt   = r_score;

    w_start = btn_start & ~r_btn_d;
    w_qual  = pixel_en & is_hit_area & hit_pixel;

    // A pixel arriving with frame_tick belongs to no frame and is dropped
    if (frame_tick) begin
      w_hit_cnt_nxt = 9'd0;
    end else if (w_qual && (r_hit_cnt != HIT_SAT)) begin
      w_hit_cnt_nxt = r_hit_cnt + 9'd1;
    end else begin
      w_hit_cnt_nxt = r_hit_cnt;
    end

    w_hit       = (r_hit_cnt >= HIT_THR) && (r_cool == 8'd0);
    w_score_inc = (r_score < SCORE_MAX) ? (r_score + 8'd1) : SCORE_MAX;

`ifdef BALL_SPEEDUP_EN
    w_mag = 8'd2 + (w_score_inc / 8'd10);
    if (w_mag > 8'd5) begin
      w_mag = 8'd5;
    end else begin
      w_mag = w_mag;
    end
    if (w_hit) begin
      w_vx_base = r_vx[10] ? -$signed({3'b000, w_mag}) : $signed({3'b000, w_mag});
    end else begin
      w_vx_base = r_vx;
    end
`else
    w_vx_base = r_vx;
`endif

    // Gravity saturates at the fall cap; a hit overrides with a jump
    if (w_hit) begin
      w_vy_upd = -JUMP;
    end else if (r_vy >= FALL_CAP) begin
      w_vy_upd = FALL_CAP;
    end else begin
      w_vy_upd = r_vy + 11'sd1;
    end

    w_new_x = $signed({1'b0, r_x}) + w_vx_base;
    w_new_y = $signed({1'b0, r_y}) + w_vy_upd;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_PLAY;
          w_score_nxt = 8'd0;
          w_vx_nxt    = VX_INIT;
          w_vy_nxt    = 11'sd0;
          w_x_nxt     = X0;
          w_y_nxt     = Y0;
          w_cool_nxt  = 8'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (w_hit) begin
            w_score_nxt = w_score_inc;
            w_cool_nxt  = COOL_INIT;
          end else if (r_cool != 8'd0) begin
            w_cool_nxt  = r_cool - 8'd1;
          end else begin
            w_cool_nxt  = r_cool;
          end

          if (w_new_x < 11'sd0) begin
            w_x_nxt  = 10'd0;
            w_vx_nxt = -w_vx_base;
          end else if (w_new_x > X_MAX) begin
            w_x_nxt  = X_MAX[9:0];
            w_vx_nxt = -w_vx_base;
          end else begin
            w_x_nxt  = w_new_x[9:0];
            w_vx_nxt = w_vx_base;
          end

          // A hit in the same frame wins over reaching the floor
          if (w_new_y < 11'sd0) begin
            w_y_nxt  = 10'd0;
            w_vy_nxt = 11'sd0;
          end else if (w_new_y >= Y_MAX) begin
            w_y_nxt  = Y_MAX[9:0];
            w_vy_nxt = w_vy_upd;
            if (!w_hit) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt = S_PLAY;
            end
          end else begin
            w_y_nxt  = w_new_y[9:0];
            w_vy_nxt = w_vy_upd;
          end
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_start) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = X0;
          w_y_nxt     = Y0;
        end else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_btn_d     <= 1'b0;
      r_hit_cnt   <= 9'd0;
      r_cool      <= 8'd0;
      r_vx        <= 11'sd0;
      r_vy        <= 11'sd0;
      r_x         <= X0;
      r_y         <= Y0;
      r_score     <= 8'd0;
      r_game_over <= 1'b0;
      r_is_idle   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_d     <= btn_start;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_cool      <= w_cool_nxt;
      r_vx        <= w_vx_nxt;
      r_vy        <= w_vy_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_score     <= w_score_nxt;
      r_game_over <= (w_state_nxt == S_OVER);
      r_is_idle   <= (w_state_nxt == S_IDLE);
    end
  end

  assign ball_x    = r_x;
  assign ball_y    = r_y;
  assign score     = r_score;
  assign game_over = r_game_over;
  assign is_idle   = r_is_idle;

endmodule

// File: tb/tb_ball_game_ctrl.sv
`timescale 1ns/1ps
module tb_ball_game_ctrl;

  localparam int H = 640, V = 480, B = 20, SX = 310, SY = 40;
  localparam int THR = 40, JUMP = 8, FALL = 8, COOL = 8;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;

  logic       clk = 1'b0;
  logic       reset, frame_tick, pixel_en, is_hit_area, hit_pixel, btn_start;
  logic [9:0] ball_x, ball_y;
  logic [7:0] score;
  logic       game_over, is_idle;

  always #5 clk = ~clk;

  ball_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pixel_en(pixel_en),
    .is_hit_area(is_hit_area), .hit_pixel(hit_pixel), .btn_start(btn_start),
    .ball_x(ball_x), .ball_y(ball_y), .score(score),
    .game_over(game_over), .is_idle(is_idle)
  );

  typedef struct {
    int x; int y; int score; int over; int idle;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cur_btn = 1'b0;
  bit   mon_prev_btn = 1'b0;
  bit   mon_trig;
  exp_t mon_e;

  // Reference model: game state as plain integers
  int m_state, m_x, m_y, m_vx, m_vy, m_score, m_cool, m_hits;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_x = SX; m_y = SY; m_score = 0;
    m_vx = 0; m_vy = 0; m_cool = 0; m_hits = 0;
  endtask

  task automatic push_expect();
    exp_t e;
    e.x = m_x; e.y = m_y; e.score = m_score;
    e.over = (m_state == M_OVER) ? 1 : 0;
    e.idle = (m_state == M_IDLE) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic model_start();
    if (m_state == M_IDLE) begin
      m_state = M_PLAY; m_score = 0; m_vx = 2; m_vy = 0;
      m_x = SX; m_y = SY; m_cool = 0;
    end else if (m_state == M_OVER) begin
      m_state = M_IDLE; m_x = SX; m_y = SY;
    end
  endtask

  task automatic model_frame();
    bit hit;
    int nx, ny;
`ifdef BALL_SPEEDUP_EN
    int mag;
`endif
    if (m_state == M_PLAY) begin
      hit = (m_hits >= THR) && (m_cool == 0);
      if (hit) begin
        m_vy = -JUMP;
        m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
        m_cool = COOL;
`ifdef BALL_SPEEDUP_EN
        mag = 2 + m_score / 10;
        if (mag > 5) mag = 5;
        m_vx = (m_vx < 0) ? -mag : mag;
`endif
      end else begin
        m_vy = (m_vy + 1 > FALL) ? FALL : m_vy + 1;
        if (m_cool > 0) m_cool--;
      end
      nx = m_x + m_vx;
      if (nx < 0) begin m_x = 0; m_vx = -m_vx; end
      else if (nx > H - B) begin m_x = H - B; m_vx = -m_vx; end
      else m_x = nx;
      ny = m_y + m_vy;
      if (ny < 0) begin m_y = 0; m_vy = 0; end
      else if (ny >= V - B) begin
        m_y = V - B;
        if (!hit) m_state = M_OVER;
      end
      else m_y = ny;
    end
    m_hits = 0;
  endtask

  // One clock cycle of stimulus; entered and left at 1ns after a rising edge
  task automatic drive(input bit ft, input bit qual);
    bit [2:0] r;
    frame_tick = ft;
    btn_start  = cur_btn;
    if (qual) begin
      pixel_en = 1'b1; is_hit_area = 1'b1; hit_pixel = 1'b1;
    end else begin
      r = 3'($urandom_range(0, 6));
      pixel_en = r[0]; is_hit_area = r[1]; hit_pixel = r[2];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic play_frame(input int nq, input int nn);
    int a, b;
    a = nq; b = nn;
    while (a + b > 0) begin
      if (a > 0 && (b == 0 || $urandom_range(0, 1) == 1)) begin
        drive(1'b0, 1'b1); a--;
        if (m_hits < 400) m_hits++;
      end else begin
        drive(1'b0, 1'b0); b--;
      end
    end
    model_frame();
    push_expect();
    drive(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic press_start(input int hold);
    model_start();
    push_expect();
    cur_btn = 1'b1;
    drive(1'b0, 1'b0);
    repeat (hold) drive(1'b0, 1'b0);
  endtask

  task automatic release_btn();
    cur_btn = 1'b0;
    drive(1'b0, 1'b0);
  endtask

  task automatic fall_to_floor();
    int f;
    f = 0;
    while (m_state == M_PLAY && f < 200) begin
      play_frame(0, $urandom_range(0, 2));
      f++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},     int'(ball_x),    SX);
    check({tag, "_y"},     int'(ball_y),    SY);
    check({tag, "_score"}, int'(score),     0);
    check({tag, "_over"},  int'(game_over), 0);
    check({tag, "_idle"},  int'(is_idle),   1);
  endtask

  // Monitor: outputs move the cycle after a frame_tick or start edge
  initial begin : monitor
    forever begin
      @(posedge clk);
      mon_trig = !reset && (frame_tick || (btn_start && !mon_prev_btn));
      mon_prev_btn = reset ? 1'b0 : btn_start;
      if (mon_trig) begin
        @(negedge clk);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: DUT event with no expected entry (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          check("ball_x",    int'(ball_x),    mon_e.x);
          check("ball_y",    int'(ball_y),    mon_e.y);
          check("score",     int'(score),     mon_e.score);
          check("game_over", int'(game_over), mon_e.over);
          check("is_idle",   int'(is_idle),   mon_e.idle);
        end
      end
    end
  end

  initial begin : stimulus
    int f, nq, sat_hits;
    reset = 1'b1; frame_tick = 1'b0; pixel_en = 1'b0;
    is_hit_area = 1'b0; hit_pixel = 1'b0; btn_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    drive(1'b0, 1'b0);

    // Idle frame: only the hit counter clears
    play_frame(5, 3);
    // Start, then first frame lands at (312,41)
    press_start(2);
    release_btn();
    play_frame(0, 2);
    // Hit, cooldown-ignored hit, cooldown expiry, threshold-1, hit
    play_frame(40, 5);
    play_frame(40, 0);
    repeat (7) play_frame(0, 1);
    play_frame(39, 3);
    play_frame(40, 0);

    // Random game, then drop to the floor
    f = 0;
    while (m_state == M_PLAY && f < 300) begin
      case ($urandom_range(0, 4))
        0, 1:    nq = 0;
        2:       nq = 39;
        3:       nq = 40;
        default: nq = $urandom_range(0, 60);
      endcase
      play_frame(nq, $urandom_range(0, 4));
      f++;
    end
    fall_to_floor();
    // OVER holds; start returns to IDLE; held button does not retrigger
    play_frame(10, 2);
    press_start(1);
    play_frame(0, 1);
    play_frame(3, 1);
    release_btn();

    // Reset in the middle of a game and a partially counted frame
    press_start(0);
    release_btn();
    play_frame(0, 1);
    repeat (30) drive(1'b0, 1'b1);
    reset = 1'b1;
    #2;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1'b0, 1'b0);
    press_start(0);
    release_btn();
    play_frame(20, 2);

    // Long game: hit at every opportunity until the score saturates
    sat_hits = 0;
    f = 0;
    while (m_state == M_PLAY && sat_hits < 3 && f < 1500) begin
      nq = (m_cool == 0) ? 40 + $urandom_range(0, 3) : 0;
      if (m_score == 99 && nq >= THR) sat_hits++;
      play_frame(nq, $urandom_range(0, 2));
      f++;
    end
    fall_to_floor();
    play_frame(0, 1);
    press_start(0);
    release_btn();
    play_frame(0, 1);

    repeat (4) drive(1'b0, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
